// File: rtl/frame_assembler.sv
// rtl/frame_assembler.sv - byte buffer that releases whole frames only, drops frames that overflow
// Optional frame-tail pattern check under FRAME_ASSEMBLER_CHECK_EN.
module frame_assembler #(
  parameter int          DEPTH   = 16,
  parameter logic [47:0] PATTERN = 48'hAABBCCDDEEFF
) (
  input  logic        clk_fast,
  input  logic        aresetn,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tlast,
`ifdef FRAME_ASSEMBLER_CHECK_EN
  output logic [31:0] err_cnt,
`endif
  output logic [31:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          drop_flag_q, drop_flag_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic full;
  logic mem_we;
  logic commit;
  logic drop_end;

  // Full is judged on the pre-read pointers, so a same-cycle read cannot make room.
  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign mem_we   = in_valid && !drop_flag_q && !full;
  assign commit   = mem_we && in_last;
  assign drop_end = in_valid && in_last && (drop_flag_q || full);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_flag_d  = drop_flag_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (commit) begin
      commit_ptr_d = wr_ptr_q + PW'(1);
      frame_cnt_d  = frame_cnt_q + 32'd1;
    end
    if (in_valid && !in_last && (drop_flag_q || full)) begin
      drop_flag_d = 1'b1;
    end
    // Abandon the partial frame: everything past the last commit is discarded.
    if (drop_end) begin
      wr_ptr_d    = commit_ptr_q;
      drop_flag_d = 1'b0;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    if (m_tvalid_q && m_tready) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    m_tvalid_d = (rd_ptr_d != commit_ptr_d);
  end

  always_ff @(posedge clk_fast) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_flag_q  <= 1'b0;
      m_tvalid_q   <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_flag_q  <= drop_flag_d;
      m_tvalid_q   <= m_tvalid_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Writes never reach an unread entry, so the head entry holds steady during a stall.
  always_ff @(posedge clk_fast) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_byte};
    end
  end

  assign {m_tlast, m_tdata} = mem_q[rd_ptr_q[AW-1:0]];
  assign m_tvalid           = m_tvalid_q;
  assign frame_cnt          = frame_cnt_q;
  assign drop_cnt           = drop_cnt_q;

`ifdef FRAME_ASSEMBLER_CHECK_EN
  logic [47:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        tail_ok;
  logic        unused_shift_hi;

  assign unused_shift_hi = ^shift_q[47:40];

  // The closing byte is still on in_byte at commit, so it is folded into the compare.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    tail_ok   = (cnt_q >= 3'd5) && ({shift_q[39:0], in_byte} == PATTERN);
    if (commit || drop_end) begin
      shift_d = '0;
      cnt_d   = '0;
      if (commit && !tail_ok) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
    end else if (mem_we) begin
      shift_d = {shift_q[39:0], in_byte};
      if (cnt_q != 3'd7) begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_fast) begin
    if (!aresetn) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_pattern;
  assign unused_pattern = ^PATTERN;
`endif

endmodule
